// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter -- iterative multiply/divide unit for the EX stage.
//
// Radix-2 shift-add multiply and restoring divide, one bit per clock. The
// pipeline stalls on `busy`. A destination tag rides along with each operation.
//
// Optional feature macro: MDU_SIGNED_EN
//   defined   : in_op[2] = 1 selects two's-complement operation. Operands are
//               turned into magnitudes at accept, and the sign is applied on the
//               edge into DONE.
//   undefined : in_op[2] is ignored. All operations are unsigned.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       synchronous abort of any operation in flight
//   in_valid    operation offered
//   in_ready    unit can accept (IDLE only)
//   in_op       [1:0] 00 MUL, 01 MULH, 10 DIV, 11 REM; [2] signed
//   in_a        multiplicand / dividend
//   in_b        multiplier / divisor
//   in_tag      destination tag
//   out_valid   result available (DONE)
//   out_ready   consumer takes the result
//   out_result  result, held stable in DONE
//   out_tag     tag of the result
//   busy        unit not idle
// -----------------------------------------------------------------------------
module mdu_iter #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [TAG_W-1:0]   r_tag;
  logic [WIDTH-1:0]   r_result;

  // Shared iteration registers. For multiply, r_hi:r_lo is the partial
  // product, with the multiplier consumed from r_lo[0]. For divide, r_hi is
  // the partial remainder and r_lo shifts the dividend out and the quotient in.
  logic               r_op_div;
  logic               r_op_sel;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_div0;
  logic               w_last;
  logic               w_finish;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_result;

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign w_div0   = in_op[1] && (in_b == '0);
  assign w_last   = (r_state == S_CALC) && (r_count == LAST);
  assign w_finish = w_last && !flush;

`ifdef MDU_SIGNED_EN
  logic w_sa;
  logic w_sb;
  logic r_neg_q;
  logic r_neg_r;

  function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v,
                                               input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_cneg_p(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  assign w_sa    = in_op[2] & in_a[WIDTH-1];
  assign w_sb    = in_op[2] & in_b[WIDTH-1];
  assign w_a_mag = f_cneg(in_a, w_sa);
  assign w_b_mag = f_cneg(in_b, w_sb);

  // The product and the quotient share the sign a^b. The remainder follows a.
  // MIN / -1 gives magnitude MIN, which negates back to MIN.
  assign w_prod = f_cneg_p({w_hi_nxt, w_lo_nxt}, r_neg_q);
  assign w_quo  = f_cneg(w_lo_nxt, r_neg_q);
  assign w_rem  = f_cneg(w_hi_nxt, r_neg_r);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
    end
  end
`else
  logic w_unused_sgn;

  assign w_unused_sgn = in_op[2];
  assign w_a_mag      = in_a;
  assign w_b_mag      = in_b;
  assign w_prod       = {w_hi_nxt, w_lo_nxt};
  assign w_quo        = w_lo_nxt;
  assign w_rem        = w_hi_nxt;
`endif

  // One multiply step: conditionally add, then shift right by one.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // One restoring-divide step. The partial remainder is always below the
  // divisor, so the shifted value is below 2*divisor. Bit WIDTH of the
  // difference is therefore a clean borrow flag.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ge    = !w_div_diff[WIDTH];

  always_comb begin
    w_hi_nxt = w_mul_sum[WIDTH:1];
    w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (r_op_div) begin
      w_hi_nxt = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ge};
    end
  end

  always_comb begin
    w_result = r_op_sel ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
    if (r_op_div) begin
      w_result = r_op_sel ? w_rem : w_quo;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_div0 ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_tag    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_count <= '0;
        r_tag   <= in_tag;
      end else if (r_state == S_CALC) begin
        r_count <= r_count + CNT_W'(1);
      end
      // Divide by zero: the quotient is all-ones and the remainder is the
      // raw dividend, in both signed and unsigned modes.
      if (w_accept && w_div0) begin
        r_result <= in_op[0] ? in_a : '1;
      end else if (w_finish) begin
        r_result <= w_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_div <= in_op[1];
      r_op_sel <= in_op[0];
      r_b      <= w_b_mag;
      r_hi     <= '0;
      r_lo     <= w_a_mag;
    end else if (r_state == S_CALC) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_result = r_result;
  assign out_tag    = r_tag;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter -- directed, table-driven bench for mdu_iter (WIDTH=16, TAG_W=3).
// Latency is the number of rising edges after the accept edge until
// out_valid is seen. It is WIDTH for a normal operation. It is 0 for divide by
// zero, which enters DONE on the accept edge itself.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic [2:0]  in_tag = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [2:0]  out_tag;
  logic        busy;

  int total = 0;
  int bad = 0;

  mdu_iter #(.WIDTH(16), .TAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  tag;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge. It returns -1 if out_valid never rises.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int seen;
    logic [15:0] hold_res;
    logic [2:0]  hold_tag;

    vecs[0]  = '{3'b000, 16'h1234, 16'h0010, 3'd5, 16'h2340, 16};
    vecs[1]  = '{3'b001, 16'h1234, 16'h0010, 3'd5, 16'h0001, 16};
    vecs[2]  = '{3'b001, 16'hFFFF, 16'hFFFF, 3'd1, 16'hFFFE, 16};
    vecs[3]  = '{3'b000, 16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, 16};
    vecs[4]  = '{3'b010, 16'd100,  16'd7,    3'd3, 16'h000E, 16};
    vecs[5]  = '{3'b011, 16'd100,  16'd7,    3'd4, 16'h0002, 16};
    vecs[6]  = '{3'b010, 16'h1234, 16'h0000, 3'd6, 16'hFFFF, 0};
    vecs[7]  = '{3'b011, 16'h1234, 16'h0000, 3'd7, 16'h1234, 0};
`ifdef MDU_SIGNED_EN
    vecs[8]  = '{3'b110, 16'hFFF9, 16'h0002, 3'd1, 16'hFFFD, 16};
    vecs[9]  = '{3'b111, 16'hFFF9, 16'h0002, 3'd2, 16'hFFFF, 16};
    vecs[10] = '{3'b110, 16'h8000, 16'hFFFF, 3'd3, 16'h8000, 16};
    vecs[11] = '{3'b111, 16'h8000, 16'hFFFF, 3'd4, 16'h0000, 16};
    vecs[12] = '{3'b101, 16'hFFFE, 16'h0003, 3'd5, 16'hFFFF, 16};
    vecs[13] = '{3'b100, 16'hFFFE, 16'h0003, 3'd6, 16'hFFFA, 16};
`else
    vecs[8]  = '{3'b110, 16'hFFF9, 16'h0002, 3'd1, 16'h7FFC, 16};
    vecs[9]  = '{3'b111, 16'hFFF9, 16'h0002, 3'd2, 16'h0001, 16};
    vecs[10] = '{3'b110, 16'h8000, 16'hFFFF, 3'd3, 16'h0000, 16};
    vecs[11] = '{3'b111, 16'h8000, 16'hFFFF, 3'd4, 16'h8000, 16};
    vecs[12] = '{3'b101, 16'hFFFE, 16'h0003, 3'd5, 16'h0002, 16};
    vecs[13] = '{3'b100, 16'hFFFE, 16'h0003, 3'd6, 16'hFFFA, 16};
`endif

    // Reset state
    #12;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_result", {16'd0, out_result}, 32'd0);
    chk("rst out_tag", {29'd0, out_tag}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int v = 0; v < NV; v++) begin
      start_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].tag);
      wait_done(lat);
      chk($sformatf("vec%0d latency", v), lat, vecs[v].lat);
      chk($sformatf("vec%0d result", v), {16'd0, out_result}, {16'd0, vecs[v].exp});
      chk($sformatf("vec%0d tag", v), {29'd0, out_tag}, {29'd0, vecs[v].tag});
      chk($sformatf("vec%0d in_ready in DONE", v), {31'd0, in_ready}, 32'd0);
      release_result();
      chk($sformatf("vec%0d in_ready after", v), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: hold DONE for 5 cycles with a competing offer present
    start_op(3'b000, 16'd3, 16'd5, 3'd2);
    wait_done(lat);
    chk("bp latency", lat, 16);
    hold_res = out_result;
    hold_tag = out_tag;
    chk("bp result", {16'd0, hold_res}, 32'd15);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = 3'b000;
    in_a = 16'd9;
    in_b = 16'd9;
    in_tag = 3'd7;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp hold result", {16'd0, out_result}, 32'd15);
      chk("bp hold tag", {29'd0, out_tag}, 32'd2);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp busy", {31'd0, busy}, 32'd1);
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    chk("bp released in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp released busy", {31'd0, busy}, 32'd0);
    chk("bp released out_valid", {31'd0, out_valid}, 32'd0);

    // Flush 8 cycles into CALC
    start_op(3'b000, 16'h1111, 16'h0003, 3'd4);
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("flush no out_valid", seen, 0);

    // Flush in IDLE blocks the accept
    @(negedge clk);
    in_valid = 1'b1;
    in_op = 3'b000;
    in_a = 16'd1;
    in_b = 16'd1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("idle flush busy", {31'd0, busy}, 32'd0);
    chk("idle flush in_ready", {31'd0, in_ready}, 32'd1);

    start_op(3'b000, 16'd3, 16'd4, 3'd6);
    wait_done(lat);
    chk("post-flush latency", lat, 16);
    chk("post-flush result", {16'd0, out_result}, 32'h000C);
    chk("post-flush tag", {29'd0, out_tag}, 32'd6);
    release_result();

    // Asynchronous reset mid-CALC
    start_op(3'b010, 16'd500, 16'd3, 3'd7);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid rst out_result", {16'd0, out_result}, 32'd0);
    chk("mid rst out_tag", {29'd0, out_tag}, 32'd0);
    chk("mid rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mid rst no output", seen, 0);

    start_op(3'b011, 16'd500, 16'd3, 3'd3);
    wait_done(lat);
    chk("post-rst latency", lat, 16);
    chk("post-rst rem", {16'd0, out_result}, 32'd2);
    chk("post-rst tag", {29'd0, out_tag}, 32'd3);
    release_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit, parametrised in operand width.
- Sits beside the single-cycle ALU in the EX stage of the RISC pipeline; the pipeline stalls while the unit is busy.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.
- Valid/ready handshake on both input and output; a destination tag travels with each operation.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 4).
- TAG_W, 3, width of destination tag (register number).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any operation in flight
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept an operation
- in_op  in  3  [1:0]: 00 MUL low, 01 MULH high, 10 DIV quotient, 11 REM; [2]: signed
- in_a  in  WIDTH  multiplicand / dividend
- in_b  in  WIDTH  multiplier / divisor
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  WIDTH  result
- out_tag  out  TAG_W  tag of result
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of clk:
  - state IDLE, count 0
  - out_valid 0, out_result 0, out_tag 0
  - in_ready 1, busy 0
- States are IDLE, CALC and DONE.
- IDLE:
  - in_ready = 1.
  - Accept on a rising edge with in_valid && in_ready && !flush.
  - On accept, latch op, operands and tag, clear the accumulator, set count = 0, and go to CALC.
  - Divide by zero: go directly to DONE instead (latency 1).
- CALC:
  - One iteration per edge, count increments.
  - On the edge with count == WIDTH-1, finish and go to DONE.
  - Result visible WIDTH cycles after the accept edge.
- DONE:
  - out_valid = 1; out_result and out_tag held stable until out_ready.
  - The edge with out_ready = 1 returns to IDLE.
  - in_ready = 0 in DONE (no same-cycle reaccept).
- in_ready is 0 in CALC and DONE, and in_valid is ignored there.
- Multiply: full 2*WIDTH product. MUL returns [WIDTH-1:0]; MULH returns [2*WIDTH-1:WIDTH].
- Divide: DIV returns the quotient, REM the remainder, truncation toward zero.
- Divide by zero: quotient all-ones, remainder = in_a.
- flush:
  - Has priority over accept and over out_ready.
  - Next state IDLE, out_valid 0, result discarded.
  - flush in IDLE with in_valid: no accept.
- Reset mid-operation: operation lost, no output produced.
- Arithmetic is modulo WIDTH/2*WIDTH; no overflow flag.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined: in_op[2] = 1 selects two's-complement operation.
  - Operands are converted to magnitudes at accept; the unsigned core runs unchanged.
  - Sign fix-up happens on the transition into DONE, with no extra cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - MULH returns the high half of the signed product.
  - Overflow case MIN / -1: quotient = MIN, remainder = 0.
  - Divide by zero: quotient -1, remainder = in_a.
- Undefined: in_op[2] is ignored and all operations are unsigned; no signed logic is synthesised.

Test Plan:
- MUL 0x1234 * 0x0010, tag 5 -> out_valid exactly 16 cycles after accept, result 0x2340, tag 5; MULH of same -> 0x0001.
- MULH 0xFFFF * 0xFFFF unsigned -> 0xFFFE; MUL -> 0x0001.
- DIV 100/7 -> 0x000E; REM 100/7 -> 0x0002; DIV 0x1234/0 -> 0xFFFF after 1 cycle; REM 0x1234/0 -> 0x1234.
- Backpressure: out_ready low for 5 cycles in DONE -> out_result/out_tag stable, in_ready 0, busy 1; out_ready high -> IDLE next edge, in_ready 1.
- flush 8 cycles into CALC -> out_valid never asserts, in_ready 1 next cycle; new MUL 3*4 -> 0x000C. rst_n low mid-CALC -> all outputs 0 immediately.
- Signed, MDU_SIGNED_EN defined:
  - op 110, 0xFFF9 / 0x0002 -> 0xFFFD; op 111 -> 0xFFFF.
  - 0x8000 / 0xFFFF -> 0x8000, rem 0x0000.
- Signed, MDU_SIGNED_EN undefined: op 110, 0xFFF9 / 0x0002 -> 0x7FFC.
